// File: rtl/switch_scan_controller_if.sv
// Event handshake between the switch scan controller and its downstream consumer.
// The controller (master) presents the head event; the consumer (slave) accepts it with EVT_READY.
interface switch_scan_controller_if;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic       EVT_DIR;
    logic [3:0] EVT_IDX;

    modport master (
        output EVT_VALID,
        output EVT_DIR,
        output EVT_IDX,
        input  EVT_READY
    );

    modport slave (
        input  EVT_VALID,
        input  EVT_DIR,
        input  EVT_IDX,
        output EVT_READY
    );
endinterface

// File: rtl/switch_scan_controller.sv
// Switch scan sequencer: walks SCAN_COUNTER over the switches one slot at a time,
// debounces the scanned switch across a full slot, records confirmed state in SW_HISTORY
// and queues each confirmed edge as a {dir, index} event in a fall-through FIFO.
module switch_scan_controller #(
    parameter int N_SW       = 10,
    parameter int SCAN_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [N_SW-1:0]          SW,
    input  logic                     SCAN_EN,
    input  logic                     OVF_CLR,
    output logic [3:0]               SCAN_COUNTER,
    output logic [N_SW-1:0]          SW_HISTORY,
    output logic [4:0]               UP_COUNT,
    output logic                     OVERFLOW,
    switch_scan_controller_if.master evt
);

    localparam int T_W   = $clog2(SCAN_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Number of confirmed-high switches.
    function automatic logic [4:0] popcount(input logic [N_SW-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N_SW; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    logic [T_W-1:0]   slot_t;
    logic             slot_end;
    logic             sw_cur;
    logic             hist_cur;
    logic             diff_q;
    logic             diff_d;
    logic             confirmed;
    logic [N_SW-1:0]  hist_nxt;

    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_valid;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic [4:0]       head_w;
    logic [4:0]       last_head;

    // Select the scanned switch and run the slot-wide debounce AND chain.
    always_comb begin
        sw_cur   = 1'b0;
        hist_cur = 1'b0;
        for (int i = 0; i < N_SW; i++) begin
            if (SCAN_COUNTER == 4'(i)) begin
                sw_cur   = SW[i];
                hist_cur = SW_HISTORY[i];
            end
        end
        slot_end   = SCAN_EN && (slot_t == T_W'(SCAN_DIV - 1));
        // The flag restarts at the first cycle of every slot; later cycles only clear it.
        diff_d     = (sw_cur != hist_cur) && ((slot_t == '0) || diff_q);
        confirmed  = slot_end && diff_d;

        fifo_valid = (count != '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        pop        = fifo_valid && evt.EVT_READY;
        // A full FIFO still accepts the edge when the head leaves on the same clock.
        push       = confirmed && (!fifo_full || pop);
        ovf_set    = confirmed && fifo_full && !pop;

        hist_nxt   = SW_HISTORY;
        for (int i = 0; i < N_SW; i++) begin
            if (SCAN_COUNTER == 4'(i)) begin
                hist_nxt[i] = SW[i];
            end
        end
        head_w     = mem[rd_ptr];
    end

    // Slot timer, scan index and debounce flag; all frozen while scanning is disabled.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            slot_t       <= '0;
            SCAN_COUNTER <= '0;
            diff_q       <= 1'b0;
        end else if (SCAN_EN) begin
            diff_q <= diff_d;
            if (slot_end) begin
                slot_t <= '0;
                if (SCAN_COUNTER == 4'(N_SW - 1)) begin
                    SCAN_COUNTER <= '0;
                end else begin
                    SCAN_COUNTER <= SCAN_COUNTER + 4'd1;
                end
            end else begin
                slot_t <= slot_t + 1'b1;
            end
        end
    end

    // Confirmed state only moves when its edge actually made it into the FIFO.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            SW_HISTORY <= '0;
        end else if (push) begin
            SW_HISTORY <= hist_nxt;
        end
    end

    // Registered popcount of the confirmed state.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            UP_COUNT <= '0;
        end else begin
            UP_COUNT <= popcount(SW_HISTORY);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the occupancy is zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {sw_cur, SCAN_COUNTER};
        end
    end

    // Remember the last presented head so the event fields hold once the FIFO drains.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            last_head <= '0;
        end else if (fifo_valid) begin
            last_head <= head_w;
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            OVERFLOW <= 1'b0;
        end else if (ovf_set) begin
            OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            OVERFLOW <= 1'b0;
        end
    end

    // Fall-through head presentation.
    always_comb begin
        evt.EVT_VALID = fifo_valid;
        {evt.EVT_DIR, evt.EVT_IDX} = fifo_valid ? head_w : last_head;
    end

endmodule

// File: tb/tb_switch_scan_controller.sv
// Directed bench for switch_scan_controller with hand-computed expectations.
// cyc counts clock edges since the last reset release (state after cyc edges).
module tb_switch_scan_controller;

    logic        CLK;
    logic        RESET_N;
    logic [9:0]  SW;
    logic        SCAN_EN;
    logic        OVF_CLR;
    logic [3:0]  SCAN_COUNTER;
    logic [9:0]  SW_HISTORY;
    logic [4:0]  UP_COUNT;
    logic        OVERFLOW;

    switch_scan_controller_if evt_if ();

    switch_scan_controller #(
        .N_SW       (10),
        .SCAN_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .SW           (SW),
        .SCAN_EN      (SCAN_EN),
        .OVF_CLR      (OVF_CLR),
        .SCAN_COUNTER (SCAN_COUNTER),
        .SW_HISTORY   (SW_HISTORY),
        .UP_COUNT     (UP_COUNT),
        .OVERFLOW     (OVERFLOW),
        .evt          (evt_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        cyc = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_sc"},   32'(SCAN_COUNTER),     32'd0);
        check_val({tag, "_hist"}, 32'(SW_HISTORY),       32'd0);
        check_val({tag, "_up"},   32'(UP_COUNT),         32'd0);
        check_val({tag, "_vld"},  32'(evt_if.EVT_VALID), 32'd0);
        check_val({tag, "_dir"},  32'(evt_if.EVT_DIR),   32'd0);
        check_val({tag, "_idx"},  32'(evt_if.EVT_IDX),   32'd0);
        check_val({tag, "_ovf"},  32'(OVERFLOW),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N          = 1'b0;
        SW               = '0;
        SCAN_EN          = 1'b1;
        OVF_CLR          = 1'b0;
        evt_if.EVT_READY = 1'b1;
        do_reset();
        check_reset_state("rst0");

        // 1: idle rotation, index walks every 4 cycles and wraps
        for (int n = 0; n <= 40; n += 4) begin
            run_to(n);
            check_val("t1_sc", 32'(SCAN_COUNTER), 32'((n / 4) % 10));
        end
        check_val("t1_vld", 32'(evt_if.EVT_VALID), 32'd0);
        check_val("t1_up",  32'(UP_COUNT),         32'd0);

        // 2: single switch up then down
        SW = 10'h008;
        run_to(56);
        check_val("t2_vld",  32'(evt_if.EVT_VALID), 32'd1);
        check_val("t2_dir",  32'(evt_if.EVT_DIR),   32'd1);
        check_val("t2_idx",  32'(evt_if.EVT_IDX),   32'd3);
        check_val("t2_hist", 32'(SW_HISTORY),       32'h008);
        check_val("t2_uplag", 32'(UP_COUNT),        32'd0);
        run_to(57);
        check_val("t2_popped", 32'(evt_if.EVT_VALID), 32'd0);
        check_val("t2_up",     32'(UP_COUNT),         32'd1);
        check_val("t2_holdidx", 32'(evt_if.EVT_IDX),  32'd3);
        check_val("t2_holddir", 32'(evt_if.EVT_DIR),  32'd1);
        SW = 10'h000;
        run_to(95);
        check_val("t2_early", 32'(evt_if.EVT_VALID), 32'd0);
        run_to(96);
        check_val("t2_dvld",  32'(evt_if.EVT_VALID), 32'd1);
        check_val("t2_ddir",  32'(evt_if.EVT_DIR),   32'd0);
        check_val("t2_didx",  32'(evt_if.EVT_IDX),   32'd3);
        check_val("t2_dhist", 32'(SW_HISTORY),       32'h000);
        run_to(97);
        check_val("t2_dup",   32'(UP_COUNT),         32'd0);

        // 3: switch 5 bounces one cycle into its slot
        run_to(130);
        SW = 10'h020;
        run_to(141);
        SW = 10'h000;
        run_to(144);
        check_val("t3_vld",  32'(evt_if.EVT_VALID), 32'd0);
        check_val("t3_hist", 32'(SW_HISTORY),       32'h000);

        // 4: consumer stalled, FIFO fills, overflow, then drain and retry
        run_to(160);
        evt_if.EVT_READY = 1'b0;
        SW = 10'h3FF;
        run_to(176);
        check_val("t4_vld",  32'(evt_if.EVT_VALID), 32'd1);
        check_val("t4_head", 32'(evt_if.EVT_IDX),   32'd0);
        check_val("t4_ovf0", 32'(OVERFLOW),         32'd0);
        run_to(180);
        check_val("t4_ovf",  32'(OVERFLOW),         32'd1);
        check_val("t4_hist", 32'(SW_HISTORY),       32'h00F);
        check_val("t4_up",   32'(UP_COUNT),         32'd4);
        run_to(181);
        OVF_CLR = 1'b1;
        run_to(182);
        check_val("t4_clr",  32'(OVERFLOW),         32'd0);
        run_to(184);
        check_val("t4_setwins", 32'(OVERFLOW),      32'd1);
        OVF_CLR = 1'b0;
        run_to(200);
        evt_if.EVT_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_to(200 + k);
            check_val("t4_drain", 32'(evt_if.EVT_IDX), 32'(k));
        end
        run_to(204);
        check_val("t4_empty",  32'(evt_if.EVT_VALID), 32'd0);
        check_val("t4_sticky", 32'(OVERFLOW),         32'd1);
        for (int k = 4; k < 10; k++) begin
            run_to(220 + 4 * (k - 4));
            check_val("t4_rvld", 32'(evt_if.EVT_VALID), 32'd1);
            check_val("t4_ridx", 32'(evt_if.EVT_IDX),   32'(k));
            check_val("t4_rdir", 32'(evt_if.EVT_DIR),   32'd1);
        end
        check_val("t4_fhist", 32'(SW_HISTORY), 32'h3FF);
        run_to(241);
        check_val("t4_fup", 32'(UP_COUNT), 32'd10);
        OVF_CLR = 1'b1;
        run_to(242);
        check_val("t4_fclr", 32'(OVERFLOW), 32'd0);
        OVF_CLR = 1'b0;

        // 5: full FIFO with a pop on the slot-end edge still accepts the push
        SW = 10'h000;
        evt_if.EVT_READY = 1'b0;
        run_to(260);
        check_val("t5_head", 32'(evt_if.EVT_IDX), 32'd1);
        check_val("t5_dir",  32'(evt_if.EVT_DIR), 32'd0);
        run_to(263);
        evt_if.EVT_READY = 1'b1;
        run_to(264);
        check_val("t5_ovf",  32'(OVERFLOW),         32'd0);
        check_val("t5_vld",  32'(evt_if.EVT_VALID), 32'd1);
        check_val("t5_idx",  32'(evt_if.EVT_IDX),   32'd2);
        check_val("t5_hist", 32'(SW_HISTORY),       32'h3C1);
        run_to(265);
        check_val("t5_idx2", 32'(evt_if.EVT_IDX),   32'd3);
        check_val("t5_up",   32'(UP_COUNT),         32'd5);

        // 6: mid-slot reset with two queued events, then frozen scan while draining
        SW = 10'h006;
        evt_if.EVT_READY = 1'b0;
        do_reset();
        check_reset_state("rst1");
        run_to(13);
        check_val("t6_vld",  32'(evt_if.EVT_VALID), 32'd1);
        check_val("t6_idx",  32'(evt_if.EVT_IDX),   32'd1);
        check_val("t6_hist", 32'(SW_HISTORY),       32'h006);
        check_val("t6_up",   32'(UP_COUNT),         32'd2);
        check_val("t6_sc",   32'(SCAN_COUNTER),     32'd3);
        RESET_N = 1'b0;
        tick();
        check_reset_state("rst2");
        RESET_N = 1'b1;
        cyc = 0;
        run_to(13);
        SCAN_EN = 1'b0;
        evt_if.EVT_READY = 1'b1;
        run_to(14);
        check_val("t6_fsc",  32'(SCAN_COUNTER),     32'd3);
        check_val("t6_fvld", 32'(evt_if.EVT_VALID), 32'd1);
        check_val("t6_fidx", 32'(evt_if.EVT_IDX),   32'd2);
        run_to(15);
        check_val("t6_evld", 32'(evt_if.EVT_VALID), 32'd0);
        check_val("t6_eidx", 32'(evt_if.EVT_IDX),   32'd2);
        check_val("t6_edir", 32'(evt_if.EVT_DIR),   32'd1);
        run_to(20);
        check_val("t6_frz",  32'(SCAN_COUNTER),     32'd3);
        SCAN_EN = 1'b1;
        run_to(22);
        check_val("t6_res3", 32'(SCAN_COUNTER),     32'd3);
        run_to(23);
        check_val("t6_res4", 32'(SCAN_COUNTER),     32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
